gpio_bus_ctrl: RTL and testbench

Memory-mapped bus slave that sits directly upstream of GPIO_register. It decodes CPU load/store requests on a valid/ready handshake and drives the register's en/wr/data_in strobes, with byte-strobe merge. It also owns the GPIO direction register, the input-pin synchronizer and a rising-edge interrupt block. Register read-back returns the GPIO_register data_out value.

---
 rtl/gpio_pkg.sv | 71 +++++++
 rtl/gpio_in_sync.sv | 48 ++++
 rtl/gpio_bus_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_gpio_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
//
// Shared definitions for the GPIO bus controller:
//   - byte offsets of the memory-mapped registers
//   - FSM state encoding (plain localparams so older tooling and waveform
//     viewers see the same numeric values)
//   - register-select enum plus the offset decoder
//   - merge_bytes(): byte-strobe merge used for the GPIO data path, the local
//     registers and the W1C clear mask
// -----------------------------------------------------------------------------
package gpio_pkg;

  // Register byte offsets. Address bits [1:0] are ignored by the decoder.
  localparam logic [31:0] GPIO_OFS_DATA   = 32'h00;
  localparam logic [31:0] GPIO_OFS_DIR    = 32'h04;
  localparam logic [31:0] GPIO_OFS_IN     = 32'h08;
  localparam logic [31:0] GPIO_OFS_IRQ_ST = 32'h0C;
  localparam logic [31:0] GPIO_OFS_IRQ_EN = 32'h10;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Widest data path merge_bytes() handles. Callers zero-extend their operands
  // and truncate the result back to their own width.
  localparam int GPIO_MAX_W  = 256;
  localparam int GPIO_MAX_SW = GPIO_MAX_W / 8;

  typedef enum logic [2:0] {
    SEL_DATA,
    SEL_DIR,
    SEL_IN,
    SEL_IRQ_ST,
    SEL_IRQ_EN,
    SEL_NONE
  } reg_sel_e;

  // Map a byte offset onto a register select; the two low bits are dropped so
  // any byte address inside a word selects that word.
  function automatic reg_sel_e decode_ofs(input logic [31:0] byte_ofs);
    logic [31:0] word_ofs;
    reg_sel_e    sel;
    word_ofs = byte_ofs & 32'hFFFF_FFFC;
    case (word_ofs)
      GPIO_OFS_DATA:   sel = SEL_DATA;
      GPIO_OFS_DIR:    sel = SEL_DIR;
      GPIO_OFS_IN:     sel = SEL_IN;
      GPIO_OFS_IRQ_ST: sel = SEL_IRQ_ST;
      GPIO_OFS_IRQ_EN: sel = SEL_IRQ_EN;
      default:         sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Per byte: strobe set -> take new_val, otherwise keep old_val.
  function automatic logic [GPIO_MAX_W-1:0] merge_bytes(
    input logic [GPIO_MAX_W-1:0]  old_val,
    input logic [GPIO_MAX_W-1:0]  new_val,
    input logic [GPIO_MAX_SW-1:0] strb
  );
    logic [GPIO_MAX_W-1:0] res;
    res = old_val;
    for (int b = 0; b < GPIO_MAX_SW; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// -----------------------------------------------------------------------------
// gpio_in_sync
//
// Brings the asynchronous GPIO pins into the clk domain through a chain of
// SYNC_STAGES flops and flags synchronized 0->1 transitions.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pin_in     raw asynchronous pin levels            [WIDTH]
//   sync_val   last synchronizer stage                [WIDTH]
//   rise_pulse one-cycle pulse per pin on a 0->1 edge [WIDTH]
// -----------------------------------------------------------------------------
module gpio_in_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise_pulse
);

  // Stage 0 is the metastability-catching flop; stage SYNC_STAGES-1 is the
  // first one safe to use as a level.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  // One extra delayed copy of the last stage for edge detection.
  logic [WIDTH-1:0]                  last_q;

  // NOTE: the synchronizer chain is reset like any other state; otherwise the
  // edge detector could report a spurious rise on the first cycles out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      last_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the value its
      // predecessor held before this edge, forming a true shift chain.
      stage_q <= {stage_q[SYNC_STAGES-2:0], pin_in};
      last_q  <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_val   = stage_q[SYNC_STAGES-1];
  assign rise_pulse = stage_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/gpio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_bus_ctrl
//
// Memory-mapped bus slave in front of an external GPIO data register. Each
// request runs IDLE -> ACCESS -> RESP; the external register is strobed during
// ACCESS and the response is presented for one cycle in RESP.
//
// Register map (byte offsets, bits [1:0] ignored):
//   0x00 DATA_OUT   RW  held in the external GPIO register
//   0x04 DIR        RW  per-pin output enable
//   0x08 DATA_IN    RO  synchronized pins (writes ignored, no error)
//   0x0C IRQ_STATUS W1C sticky rising-edge flags, set wins over clear
//   0x10 IRQ_EN     RW  interrupt mask
//   other           read 0 / write ignored, bus_err=1
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   bus_valid/we/addr/wdata/wstrb      request (held until bus_ready)
//   bus_ready/rdata/err                one-cycle completion and response
//   gpio_en/wr/wdata, gpio_rdata       strobes to / data from GPIO register
//   gpio_in                            asynchronous pin inputs
//   gpio_oe                            per-pin output enable (= DIR)
//   irq                                level interrupt, registered
// -----------------------------------------------------------------------------
module gpio_bus_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bus_valid,
  input  logic               bus_we,
  input  logic [ADDR_W-1:0]  bus_addr,
  input  logic [WIDTH-1:0]   bus_wdata,
  input  logic [WIDTH/8-1:0] bus_wstrb,
  output logic               bus_ready,
  output logic [WIDTH-1:0]   bus_rdata,
  output logic               bus_err,
  output logic               gpio_en,
  output logic               gpio_wr,
  output logic [WIDTH-1:0]   gpio_wdata,
  input  logic [WIDTH-1:0]   gpio_rdata,
  input  logic [WIDTH-1:0]   gpio_in,
  output logic [WIDTH-1:0]   gpio_oe,
  output logic               irq
);

  import gpio_pkg::*;

  localparam int SW = WIDTH / 8;

  // Narrow wrapper around the package merge for this instance's width.
  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] new_val,
    input logic [SW-1:0]    strb
  );
    return WIDTH'(merge_bytes(GPIO_MAX_W'(old_val), GPIO_MAX_W'(new_val),
                              GPIO_MAX_SW'(strb)));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic [SW-1:0]     lat_wstrb;

  logic [WIDTH-1:0]  dir_q;
  logic [WIDTH-1:0]  irq_st_q;
  logic [WIDTH-1:0]  irq_en_q;

  logic [WIDTH-1:0]  sync_val;
  logic [WIDTH-1:0]  rise_pulse;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detector
  // ---------------------------------------------------------------------------
  gpio_in_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_in     (gpio_in),
    .sync_val   (sync_val),
    .rise_pulse (rise_pulse)
  );

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic     accept;     // request taken at this edge
  reg_sel_e req_sel;    // select of the request on the bus (IDLE)
  reg_sel_e acc_sel;    // select of the latched request (ACCESS)
  logic     acc_wr_en;  // latched write being executed this cycle
  logic     req_data_wr;

  assign accept      = (state_q == ST_IDLE) && bus_valid;
  assign req_sel     = decode_ofs(32'(bus_addr));
  assign acc_sel     = decode_ofs(32'(lat_addr));
  assign acc_wr_en   = (state_q == ST_ACCESS) && lat_we;
  assign req_data_wr = accept && bus_we && (req_sel == SEL_DATA);

  // Bit mask of the strobed bytes; W1C clears only the 1s inside that mask.
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] w1c_clr;
  logic [WIDTH-1:0] irq_st_d;

  assign wr_mask  = merge_w('0, {WIDTH{1'b1}}, lat_wstrb);
  assign w1c_clr  = (acc_wr_en && (acc_sel == SEL_IRQ_ST)) ? (lat_wdata & wr_mask) : '0;
  // A rise in the same cycle as its clear keeps the flag set.
  assign irq_st_d = (irq_st_q & ~w1c_clr) | rise_pulse;

  // Response data computed during ACCESS, registered into RESP.
  logic [WIDTH-1:0] acc_rdata;
  logic             acc_err;

  // NOTE: every signal assigned in this always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_rdata = '0;
    acc_err   = 1'b0;
    case (acc_sel)
      SEL_DATA:   acc_rdata = gpio_rdata;
      SEL_DIR:    acc_rdata = dir_q;
      SEL_IN:     acc_rdata = sync_val;
      SEL_IRQ_ST: acc_rdata = irq_st_q;
      SEL_IRQ_EN: acc_rdata = irq_en_q;
      default:    acc_err   = 1'b1;
    endcase
    // Writes complete with zero data; only the error flag is meaningful.
    if (lat_we) acc_rdata = '0;
  end

  // ---------------------------------------------------------------------------
  // FSM and request latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_valid) begin
            lat_we    <= bus_we;
            lat_addr  <= bus_addr;
            lat_wdata <= bus_wdata;
            lat_wstrb <= bus_wstrb;
            state_q   <= ST_ACCESS;
          end
        end
        // bus_valid is not looked at again: a dropped request still completes.
        ST_ACCESS: state_q <= ST_RESP;
        ST_RESP:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // GPIO register strobes: loaded on the accepting edge so they are high for
  // exactly the ACCESS cycle. The current gpio_rdata is stable until this very
  // strobe lands, so merging against it here gives the ACCESS-time value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_en    <= 1'b0;
      gpio_wr    <= 1'b0;
      gpio_wdata <= '0;
    end else begin
      gpio_en <= accept && (req_sel == SEL_DATA);
      gpio_wr <= req_data_wr;
      if (req_data_wr) gpio_wdata <= merge_w(gpio_rdata, bus_wdata, bus_wstrb);
    end
  end

  // ---------------------------------------------------------------------------
  // Response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_ready <= (state_q == ST_ACCESS);
      if (state_q == ST_ACCESS) begin
        bus_rdata <= acc_rdata;
        bus_err   <= acc_err;
      end else begin
        bus_rdata <= '0;
        bus_err   <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Local registers and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= '0;
      irq_en_q <= '0;
      irq_st_q <= '0;
      irq      <= 1'b0;
    end else begin
      if (acc_wr_en && (acc_sel == SEL_DIR))
        dir_q <= merge_w(dir_q, lat_wdata, lat_wstrb);
      if (acc_wr_en && (acc_sel == SEL_IRQ_EN))
        irq_en_q <= merge_w(irq_en_q, lat_wdata, lat_wstrb);
      irq_st_q <= irq_st_d;
      irq      <= |(irq_st_q & irq_en_q);
    end
  end

  assign gpio_oe = dir_q;

endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_bus_ctrl
//
// Drives bus requests against gpio_bus_ctrl with a behavioural model of the
// downstream GPIO data register. Expected responses are queued when a request
// is issued and compared when bus_ready appears.
// -----------------------------------------------------------------------------
module tb_gpio_bus_ctrl;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [WIDTH-1:0]  bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_ready;
  logic [WIDTH-1:0]  bus_rdata;
  logic              bus_err;
  logic              gpio_en;
  logic              gpio_wr;
  logic [WIDTH-1:0]  gpio_wdata;
  logic [WIDTH-1:0]  gpio_rdata;
  logic [WIDTH-1:0]  gpio_in;
  logic [WIDTH-1:0]  gpio_oe;
  logic              irq;

  always #5 clk = ~clk;

  gpio_bus_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err),
    .gpio_en    (gpio_en),
    .gpio_wr    (gpio_wr),
    .gpio_wdata (gpio_wdata),
    .gpio_rdata (gpio_rdata),
    .gpio_in    (gpio_in),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  // Model of the downstream GPIO data register.
  logic [WIDTH-1:0] model_q = '0;
  always @(posedge clk) if (gpio_en && gpio_wr) model_q <= gpio_wdata;
  assign gpio_rdata = model_q;

  // Scoreboard.
  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Strobes observed during the ACCESS cycle of the last transfer.
  logic        acc_en;
  logic        acc_wr;
  logic [31:0] acc_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT
  // idle again.
  task automatic bus_xfer(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic chk_rd, input logic [31:0] exp_rdata,
                          input logic exp_err);
    exp_t e;
    int   cyc;
    e.chk_rd = chk_rd;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    exp_q.push_back(e);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    acc_en    = gpio_en;
    acc_wr    = gpio_wr;
    acc_wdata = gpio_wdata;
    cyc = 1;
    while (!bus_ready && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    e = exp_q.pop_front();
    if (bus_ready) begin
      check({tag, " latency"}, 32'(cyc), 32'd2);
      if (e.chk_rd) check({tag, " rdata"}, bus_rdata, e.rdata);
      check({tag, " err"}, 32'(bus_err), 32'(e.err));
    end else begin
      check({tag, " bus_ready timeout"}, 32'd0, 32'd1);
    end
    bus_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] d,
                    input logic [3:0] strb, input logic exp_err);
    bus_xfer(tag, 1'b1, addr, d, strb, 1'b0, 32'h0, exp_err);
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp_d,
                    input logic exp_err);
    bus_xfer(tag, 1'b0, addr, 32'h0, 4'h0, 1'b1, exp_d, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen;

    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    gpio_in   = '1;

    // Reset state with all pins high.
    repeat (3) @(negedge clk);
    check("rst ready/err/en/wr/irq", {27'd0, bus_ready, bus_err, gpio_en, gpio_wr, irq}, 32'd0);
    check("rst rdata", bus_rdata, 32'h0);
    check("rst gpio_wdata", gpio_wdata, 32'h0);
    check("rst gpio_oe", gpio_oe, 32'h0);

    // Out of reset the high pins look like rising edges once synchronized.
    rst_n = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    check("irq masked", 32'(irq), 32'd0);
    rd("irq_st after reset", 5'h0C, 32'hFFFF_FFFF, 1'b0);
    rd("data_in high", 5'h08, 32'hFFFF_FFFF, 1'b0);
    gpio_in = '0;
    repeat (4) @(negedge clk);
    wr("w1c all", 5'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd("irq_st cleared", 5'h0C, 32'h0, 1'b0);

    // Full write of DATA_OUT.
    wr("data wr", 5'h00, 32'hA5A5_A5A5, 4'hF, 1'b0);
    check("data wr en/wr", {30'd0, acc_en, acc_wr}, 32'd3);
    check("data wr wdata", acc_wdata, 32'hA5A5_A5A5);
    rd("data rd", 5'h00, 32'hA5A5_A5A5, 1'b0);
    check("data rd en/wr", {30'd0, acc_en, acc_wr}, 32'd2);

    // Partial write merges with the register contents.
    wr("data partial", 5'h00, 32'h1234_5678, 4'b0011, 1'b0);
    check("partial wdata", acc_wdata, 32'hA5A5_5678);
    rd("partial rd", 5'h02, 32'hA5A5_5678, 1'b0);

    // Zero strobes: strobes still fire, data unchanged.
    wr("data nostrb", 5'h00, 32'hDEAD_BEEF, 4'h0, 1'b0);
    check("nostrb en/wr", {30'd0, acc_en, acc_wr}, 32'd3);
    check("nostrb wdata", acc_wdata, 32'hA5A5_5678);

    // Rising-edge interrupt on pin 3.
    wr("irq_en wr", 5'h10, 32'h0000_0008, 4'hF, 1'b0);
    rd("irq_en rd", 5'h10, 32'h0000_0008, 1'b0);
    check("irq idle", 32'(irq), 32'd0);
    gpio_in[3] = 1'b1;
    cyc = 0;
    while (!irq && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("irq raised in time", 32'(irq && cyc <= SYNC_STAGES + 2), 32'd1);
    rd("irq_st bit3", 5'h0C, 32'h0000_0008, 1'b0);
    wr("w1c bit3", 5'h0C, 32'h0000_0008, 4'hF, 1'b0);
    rd("irq_st after w1c", 5'h0C, 32'h0, 1'b0);
    check("irq dropped", 32'(irq), 32'd0);

    // Rise on pin 4 lands in the same cycle as its W1C: set wins.
    gpio_in[4] = 1'b1;
    @(negedge clk);
    wr("w1c vs rise", 5'h0C, 32'h0000_0010, 4'hF, 1'b0);
    rd("set wins", 5'h0C, 32'h0000_0010, 1'b0);
    wr("w1c bit4 unstrobed", 5'h0C, 32'h0000_0010, 4'b1110, 1'b0);
    rd("unstrobed kept", 5'h0C, 32'h0000_0010, 1'b0);
    wr("w1c bit4", 5'h0C, 32'h0000_0010, 4'b0001, 1'b0);
    rd("bit4 cleared", 5'h0C, 32'h0, 1'b0);

    // Unmapped and read-only offsets.
    rd("unmapped rd", 5'h14, 32'h0, 1'b1);
    wr("unmapped wr", 5'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1);
    wr("data_in wr", 5'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd("data_in rd", 5'h08, 32'h0000_0018, 1'b0);

    // Direction register.
    wr("dir wr", 5'h04, 32'h0000_FFFF, 4'hF, 1'b0);
    check("gpio_oe", gpio_oe, 32'h0000_FFFF);
    wr("dir partial", 5'h04, 32'hFF00_0000, 4'b1000, 1'b0);
    rd("dir rd", 5'h04, 32'hFF00_FFFF, 1'b0);
    check("data untouched", model_q, 32'hA5A5_5678);

    // Reset pulsed during ACCESS of a DATA_OUT write.
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 5'h00;
    bus_wdata = 32'h1111_1111;
    bus_wstrb = 4'hF;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort en/wr/ready", {29'd0, gpio_en, gpio_wr, bus_ready}, 32'd0);
    bus_valid = 1'b0;
    rst_n     = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_ready) seen = 1'b1;
    end
    check("abort no ready", 32'(seen), 32'd0);
    check("abort no write", model_q, 32'hA5A5_5678);
    rd("post-abort data", 5'h00, 32'hA5A5_5678, 1'b0);
    rd("post-abort dir", 5'h04, 32'h0, 1'b0);
    check("post-abort oe", gpio_oe, 32'h0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
